// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
// Module      : display_pkg
// Description : Shared constants and helpers for the multiplexed display
//               scanner: anode-off pattern, active-low one-hot anode helper
//               and the digit-index width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package display_pkg;

    // Upper bound on supported digit count (anode helper width).
    localparam int MAX_DIGITS = 32;

    // All anodes inactive (common-anode bank, active-low enables).
    localparam logic [MAX_DIGITS-1:0] ANODE_OFF = '1;

    // Width of a digit index able to address DIGITS positions (minimum 1 bit).
    function automatic int unsigned idx_width(input int unsigned digits);
        return (digits > 1) ? $clog2(digits) : 1;
    endfunction

    // Active-low one-hot enable for digit idx; out-of-range idx yields all off.
    function automatic logic [MAX_DIGITS-1:0] onehot_n(input int unsigned idx,
                                                       input int unsigned digits);
        logic [MAX_DIGITS-1:0] v;
        v = ANODE_OFF;
        if (idx < digits) begin
            v = ANODE_OFF & ~(MAX_DIGITS'(1) << idx);
        end
        return v;
    endfunction

endpackage : display_pkg
`default_nettype wire

// File: rtl/refresh_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : refresh_prescaler
// Description : Free-running 0..REFRESH_DIV-1 counter; tick is high during
//               the last count of each digit slot.
// Revision    : 1.0 - initial release
// ============================================================================
module refresh_prescaler #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int                CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0]  C_LAST = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign tick = (count_q == C_LAST);

    // Wrap to zero after the last count, otherwise increment.
    always_comb begin
        count_d = count_q + 1'b1;
        if (tick) begin
            count_d = '0;
        end
    end

    // Counter register, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule : refresh_prescaler
`default_nettype wire

// File: rtl/display_scanner.sv
`default_nettype none
// ============================================================================
// Module      : display_scanner
// Description : Time-multiplexes a packed DIGITS x N hex value onto a shared
//               seven-segment decoder and a common-anode digit bank.
//               Loads go to a shadow buffer and are copied into the display
//               buffer only at frame boundaries, so a frame never tears.
// Revision    : 1.0 - initial release
// ============================================================================
module display_scanner
    import display_pkg::*;
#(
    parameter int N           = 4,
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DIGITS*N-1:0] value,
    input  logic                load,
    input  logic                blankLeading,
    output logic                ready,
    output logic [N-1:0]        digitNibble,
    output logic [DIGITS-1:0]   anodeN,
    output logic                frameStart
);

    localparam int IDX_W = idx_width(DIGITS);
    typedef logic [IDX_W-1:0] digit_idx_t;
    localparam digit_idx_t C_LAST_IDX = IDX_W'(DIGITS - 1);

    logic                w_tick;
    logic                w_last;
    logic                w_boundary;
    logic                w_accept;
    logic                w_blank;

    digit_idx_t          idx_q,     idx_d;
    logic [DIGITS*N-1:0] display_q, display_d;
    logic [DIGITS*N-1:0] shadow_q,  shadow_d;
    logic                pending_q, pending_d;
    logic                ready_q;
    logic                wrap_q;
    logic [N-1:0]        nibble_q,  nibble_d;
    logic [DIGITS-1:0]   anode_q,   anode_d;
    logic                frame_q;

    refresh_prescaler #(
        .REFRESH_DIV (REFRESH_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (w_tick)
    );

    assign w_last     = (idx_q == C_LAST_IDX);
    assign w_boundary = w_tick && w_last;
    assign w_accept   = load && ready_q;

    // Digit index, buffer transfer and load acceptance next-state.
    always_comb begin
        idx_d     = idx_q;
        display_d = display_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        if (w_tick) begin
            idx_d = w_last ? '0 : idx_q + 1'b1;
        end
        // Boundary uses the pre-edge pending, so a same-edge accept waits a frame.
        if (w_boundary && pending_q) begin
            display_d = shadow_q;
            pending_d = 1'b0;
        end
        if (w_accept) begin
            shadow_d  = value;
            pending_d = 1'b1;
        end
    end

    // Output decode for the currently selected digit, with leading-zero blanking.
    always_comb begin
        w_blank  = blankLeading && (idx_q != '0) &&
                   ((display_q >> (int'(idx_q) * N)) == '0);
        nibble_d = N'(display_q >> (int'(idx_q) * N));
        anode_d  = DIGITS'(onehot_n(int'(idx_q), DIGITS));
        if (w_blank) begin
            nibble_d = '0;
            anode_d  = DIGITS'(ANODE_OFF);
        end
    end

    // State and registered outputs; frameStart trails the wrap by one cycle
    // so it lines up with the first output cycle showing digit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q     <= '0;
            display_q <= '0;
            shadow_q  <= '0;
            pending_q <= 1'b0;
            ready_q   <= 1'b1;
            wrap_q    <= 1'b0;
            nibble_q  <= '0;
            anode_q   <= '1;
            frame_q   <= 1'b0;
        end else begin
            idx_q     <= idx_d;
            display_q <= display_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            ready_q   <= ~pending_d;
            wrap_q    <= w_boundary;
            nibble_q  <= nibble_d;
            anode_q   <= anode_d;
            frame_q   <= wrap_q;
        end
    end

    assign ready       = ready_q;
    assign digitNibble = nibble_q;
    assign anodeN      = anode_q;
    assign frameStart  = frame_q;

endmodule : display_scanner
`default_nettype wire

// File: tb/tb_display_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_display_scanner
// Description : Self-checking bench for display_scanner (N=4, DIGITS=4,
//               REFRESH_DIV=4). A timeline model derives expected outputs
//               from the edge count since reset; directed scenarios pin the
//               model with literal values, then random traffic follows.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_display_scanner;

    localparam int N      = 4;
    localparam int DIGITS = 4;
    localparam int DIV    = 4;
    localparam int FRAME  = DIV * DIGITS;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] value = '0;
    logic        load = 1'b0;
    logic        blankLeading = 1'b0;
    logic        ready;
    logic [3:0]  digitNibble;
    logic [3:0]  anodeN;
    logic        frameStart;

    int tests = 0;
    int fails = 0;

    display_scanner #(
        .N           (N),
        .DIGITS      (DIGITS),
        .REFRESH_DIV (DIV)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .value        (value),
        .load         (load),
        .blankLeading (blankLeading),
        .ready        (ready),
        .digitNibble  (digitNibble),
        .anodeN       (anodeN),
        .frameStart   (frameStart)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Timeline model: outputs after edge k show digit ((k-1)/DIV)%DIGITS of
    // the display content held after edge k-1; boundaries are edges that
    // are multiples of FRAME.
    // ------------------------------------------------------------------
    int unsigned m_edge = 0;
    logic [15:0] m_disp = '0;
    logic [15:0] m_shadow = '0;
    bit          m_pend = 1'b0;

    always @(posedge clk or negedge rst_n) begin : model
        int         idx;
        bit         blank, e_fs, bnd, acc;
        logic [3:0] e_nib, e_an;
        if (!rst_n) begin
            m_edge   = 0;
            m_disp   = '0;
            m_shadow = '0;
            m_pend   = 1'b0;
            #1;
            chk("reset_anodeN", anodeN, 16'hF);
            chk("reset_nibble", digitNibble, 16'h0);
            chk("reset_ready", ready, 16'h1);
            chk("reset_frameStart", frameStart, 16'h0);
        end else begin
            m_edge++;
            idx   = ((m_edge - 1) / DIV) % DIGITS;
            blank = blankLeading && (idx > 0) && ((m_disp >> (4 * idx)) == 16'h0);
            e_nib = blank ? 4'h0 : 4'(m_disp >> (4 * idx));
            e_an  = blank ? 4'hF : ~(4'b0001 << idx);
            e_fs  = (m_edge >= 2) && (((m_edge - 1) % FRAME) == 0);
            bnd   = ((m_edge % FRAME) == 0) && m_pend;
            acc   = load && !m_pend;
            if (bnd) begin
                m_disp = m_shadow;
                m_pend = 1'b0;
            end
            if (acc) begin
                m_shadow = value;
                m_pend   = 1'b1;
            end
            #1;
            chk("model_nibble", digitNibble, e_nib);
            chk("model_anodeN", anodeN, e_an);
            chk("model_frameStart", frameStart, e_fs);
            chk("model_ready", ready, !m_pend);
        end
    end

    // Wait (at negedges) for frameStart, bounded.
    task automatic wait_fs(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 4 * FRAME; i++) begin
            @(negedge clk);
            if (frameStart) begin
                seen = 1'b1;
                break;
            end
        end
        chk({name, "_frameStart_seen"}, seen, 16'h1);
    endtask

    // Called on the frameStart cycle: walk all four slots against literals.
    task automatic check_frame(input string name, input logic [15:0] nibs,
                               input logic [15:0] anodes);
        for (int d = 0; d < DIGITS; d++) begin
            if (d > 0) repeat (DIV) @(negedge clk);
            chk({name, "_nib"}, digitNibble, nibs[d*4 +: 4]);
            chk({name, "_anode"}, anodeN, anodes[d*4 +: 4]);
        end
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [15:0] mask;
        int          guard;

        // Reset and free-running scan of an all-zero display.
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);                                  // after edge 1
        chk("first_slot_anode", anodeN, 16'hE);
        chk("first_slot_nibble", digitNibble, 16'h0);
        chk("first_slot_ready", ready, 16'h1);
        repeat (4) @(negedge clk);
        chk("slot1_anode", anodeN, 16'hD);
        repeat (4) @(negedge clk);
        chk("slot2_anode", anodeN, 16'hB);
        repeat (4) @(negedge clk);
        chk("slot3_anode", anodeN, 16'h7);
        repeat (4) @(negedge clk);                       // after edge 17
        chk("wrap_anode", anodeN, 16'hE);
        chk("wrap_frameStart", frameStart, 16'h1);

        // Mid-frame load of 1A3F.
        load  = 1'b1;
        value = 16'h1A3F;
        @(negedge clk);
        load = 1'b0;
        chk("load_ready_low", ready, 16'h0);
        chk("load_pre_xfer_nib", digitNibble, 16'h0);
        wait_fs("load");
        chk("load_ready_high", ready, 16'h1);
        check_frame("load_1A3F", 16'h1A3F, 16'h7BDE);

        // Reload 1A3F, then BEEF while ready is low (ignored).
        load  = 1'b1;
        value = 16'h1A3F;
        @(negedge clk);
        value = 16'hBEEF;
        @(negedge clk);
        chk("ignored_ready_low", ready, 16'h0);
        load = 1'b0;
        wait_fs("ign1");
        wait_fs("ign2");
        check_frame("ignored_BEEF", 16'h1A3F, 16'h7BDE);

        // Leading-zero blanking.
        blankLeading = 1'b1;
        load  = 1'b1;
        value = 16'h0030;
        @(negedge clk);
        load = 1'b0;
        wait_fs("blank");
        check_frame("blank_on", 16'h0030, 16'hFFDE);
        blankLeading = 1'b0;
        wait_fs("noblank");
        check_frame("blank_off", 16'h0030, 16'h7BDE);

        // Accept on the exact boundary edge: display changes two frameStarts later.
        guard = 0;
        while (((m_edge % FRAME) != FRAME - 1) && (guard < 2 * FRAME)) begin
            @(negedge clk);
            guard++;
        end
        chk("bnd_align", ((m_edge % FRAME) == FRAME - 1), 16'h1);
        load  = 1'b1;
        value = 16'h5A5A;
        @(negedge clk);
        load = 1'b0;
        chk("bnd_ready_low", ready, 16'h0);
        wait_fs("bnd1");
        chk("bnd_first_fs_old_nib", digitNibble, 16'h0);
        chk("bnd_first_fs_ready", ready, 16'h0);
        wait_fs("bnd2");
        chk("bnd_second_fs_new_nib", digitNibble, 16'hA);
        chk("bnd_second_fs_anode", anodeN, 16'hE);
        chk("bnd_second_fs_ready", ready, 16'h1);

        // Asynchronous reset mid-slot with a pending load.
        load  = 1'b1;
        value = 16'h1111;
        @(negedge clk);
        load = 1'b0;
        chk("rst_pending_ready", ready, 16'h0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_anode", anodeN, 16'hF);
        chk("async_rst_ready", ready, 16'h1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_anode", anodeN, 16'hE);
        chk("post_rst_ready", ready, 16'h1);
        wait_fs("post_rst");
        check_frame("post_rst", 16'h0000, 16'h7BDE);

        // Random traffic against the model.
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            case ($urandom_range(0, 3))
                0:       mask = 16'h000F;
                1:       mask = 16'h00FF;
                2:       mask = 16'h0FFF;
                default: mask = 16'hFFFF;
            endcase
            value = 16'($urandom) & mask;
            load  = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 63) == 0) blankLeading = ~blankLeading;
        end
        load = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_display_scanner
`default_nettype wire
